// File: rtl/fetch_pc_ctrl_pkg.sv
// rtl/fetch_pc_ctrl_pkg.sv - shared fetch types and defaults
package fetch_pc_ctrl_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h1c00_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0340_0000;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } fetch_buf_t;

endpackage

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch PC owner, one-outstanding I-cache requester and fetch buffer
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_ifbr,
    input  logic [31:0] ex_brtarget,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_addr_ok,
    input  logic        ic_data_ok,
    input  logic [31:0] ic_rdata,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adef,
    output logic        flush_id
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         discard_q, discard_d;
    fetch_buf_t   buf_q, buf_d;

    logic redirect;
    logic buffer_free;
    logic misaligned;

    assign redirect    = ex_valid & ex_ifbr;
    assign buffer_free = !buf_q.valid | id_ready;
    assign misaligned  = (pc_q[1:0] != 2'b00);

    assign flush_id = redirect;
    assign ic_req   = (state_q == ST_REQ) && buffer_free && !misaligned;
    assign ic_addr  = pc_q;

    assign if_valid = buf_q.valid;
    assign if_pc    = buf_q.pc;
    assign if_inst  = buf_q.inst;
    assign if_adef  = buf_q.adef;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        buf_d     = buf_q;

        if (buf_q.valid && id_ready) begin
            buf_d.valid = 1'b0;
        end

        case (state_q)
            ST_REQ: begin
                if (misaligned && buffer_free) begin
                    // Misaligned PC never reaches the I-cache; decode gets the exception instead.
                    buf_d = '{valid: 1'b1, pc: pc_q, inst: NOP_INST, adef: 1'b1};
                end else if (ic_req && ic_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ic_data_ok) begin
                    if (!discard_q) begin
                        buf_d = '{valid: 1'b1, pc: pc_q, inst: ic_rdata, adef: 1'b0};
                        pc_d  = pc_q + 32'd4;
                    end
                    discard_d = 1'b0;
                    state_d   = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // A redirect overrides everything; the only response still owed is marked stale.
        if (redirect) begin
            pc_d        = ex_brtarget;
            buf_d.valid = 1'b0;
            discard_d   = (state_d == ST_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            buf_q     <= buf_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - directed scoreboard bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam logic [31:0] NOP    = 32'h0340_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ifbr;
    logic [31:0] ex_brtarget;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_addr_ok;
    logic        ic_data_ok;
    logic [31:0] ic_rdata;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adef;
    logic        flush_id;

    int total = 0;
    int bad   = 0;

    logic [31:0] req_q[$];
    logic [64:0] fetch_q[$];

    logic        pending;
    int          cnt;
    int          lat;
    logic [31:0] resp;
    logic        force_en;
    logic [31:0] force_val;
    logic        last_acc;
    logic [31:0] last_addr;

    fetch_pc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_ifbr     (ex_ifbr),
        .ex_brtarget (ex_brtarget),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .ic_addr_ok  (ic_addr_ok),
        .ic_data_ok  (ic_data_ok),
        .ic_rdata    (ic_rdata),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_adef     (if_adef),
        .flush_id    (flush_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_5a5a;
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_nonempty(input string tag, input int size);
        total++;
        assert (size != 0) else begin
            bad++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end
    endtask

    // One clock: observe at negedge, then drive the I-cache model 1 time unit after posedge.
    task automatic tick();
        @(negedge clk);
        last_acc  = ic_req && ic_addr_ok;
        last_addr = ic_addr;
        if (last_acc && !rst) begin
            chk_nonempty("req_extra", req_q.size());
            if (req_q.size() != 0) chk("req_addr", {33'd0, ic_addr}, {33'd0, req_q.pop_front()});
        end
        if (if_valid && id_ready && !rst) begin
            chk_nonempty("fetch_extra", fetch_q.size());
            if (fetch_q.size() != 0) chk("fetch_entry", {if_pc, if_inst, if_adef}, fetch_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (ic_data_ok) pending = 1'b0;
            if (last_acc) begin
                pending = 1'b1;
                cnt     = lat;
                resp    = force_en ? force_val : inst_of(last_addr);
            end else if (pending && cnt > 1) begin
                cnt = cnt - 1;
            end
        end
        ic_data_ok = pending && (cnt == 1);
        ic_rdata   = ic_data_ok ? resp : 32'd0;
    endtask

    task automatic run_accepts(input int n);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 50) begin
            tick();
            if (last_acc) got++;
            budget++;
        end
        total++;
        assert (got == n) else begin
            bad++;
            $error("FAIL accept_timeout observed=%0d expected=%0d", got, n);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_fetch(input logic [31:0] pc);
        req_q.push_back(pc);
        fetch_q.push_back({pc, inst_of(pc), 1'b0});
    endtask

    task automatic set_redirect(input logic on, input logic [31:0] tgt);
        ex_valid    = on;
        ex_ifbr     = on;
        ex_brtarget = tgt;
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_ifbr = 1'b0; ex_brtarget = 32'd0;
        ic_addr_ok = 1'b0; ic_data_ok = 1'b0; ic_rdata = 32'd0; id_ready = 1'b1;
        pending = 1'b0; cnt = 0; lat = 1; resp = 32'd0; force_en = 1'b0; force_val = 32'd0;
        last_acc = 1'b0; last_addr = 32'd0;

        ticks(2);
        rst = 1'b0;
        chk("rst_if_valid", {64'd0, if_valid}, 65'd0);
        chk("rst_if_pc", {33'd0, if_pc}, 65'd0);
        chk("rst_if_inst", {33'd0, if_inst}, 65'd0);
        chk("rst_if_adef", {64'd0, if_adef}, 65'd0);
        chk("rst_ic_addr", {33'd0, ic_addr}, {33'd0, RST_PC});
        chk("rst_ic_req", {64'd0, ic_req}, 65'd1);

        // Streaming fetch
        push_fetch(32'h1c00_0000);
        push_fetch(32'h1c00_0004);
        push_fetch(32'h1c00_0008);
        ic_addr_ok = 1'b1;
        run_accepts(3);
        ic_addr_ok = 1'b0;
        ticks(3);

        // Decode back-pressure
        id_ready = 1'b0;
        push_fetch(32'h1c00_000c);
        ic_addr_ok = 1'b1;
        run_accepts(1);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ic_req", {64'd0, ic_req}, 65'd0);
            chk("stall_if_pc", {33'd0, if_pc}, {33'd0, 32'h1c00_000c});
        end
        push_fetch(32'h1c00_0010);
        id_ready = 1'b1;
        run_accepts(1);
        ic_addr_ok = 1'b0;
        ticks(3);

        // Redirect while waiting; stale DEADBEEF arrives later
        req_q.push_back(32'h1c00_0014);
        force_en = 1'b1; force_val = 32'hdead_beef; lat = 3;
        ic_addr_ok = 1'b1;
        run_accepts(1);
        ic_addr_ok = 1'b0;
        force_en = 1'b0;
        set_redirect(1'b1, 32'h1c00_0100);
        tick();
        chk("wait_flush_on", {64'd0, flush_id}, 65'd1);
        set_redirect(1'b0, 32'd0);
        tick();
        chk("wait_flush_off", {64'd0, flush_id}, 65'd0);
        tick();
        chk("wait_if_valid", {64'd0, if_valid}, 65'd0);
        chk("wait_next_addr", {32'd0, ic_req, ic_addr}, {32'd0, 1'b1, 32'h1c00_0100});
        lat = 1;
        push_fetch(32'h1c00_0100);
        ic_addr_ok = 1'b1;
        run_accepts(1);
        ic_addr_ok = 1'b0;
        ticks(3);

        // Redirect coincident with data_ok
        req_q.push_back(32'h1c00_0104);
        lat = 2;
        ic_addr_ok = 1'b1;
        run_accepts(1);
        ic_addr_ok = 1'b0;
        tick();
        chk("data_ok_present", {64'd0, ic_data_ok}, 65'd1);
        set_redirect(1'b1, 32'h1c00_0200);
        tick();
        chk("same_data_flush", {64'd0, flush_id}, 65'd1);
        set_redirect(1'b0, 32'd0);
        chk("same_data_if_valid", {64'd0, if_valid}, 65'd0);
        lat = 1;
        push_fetch(32'h1c00_0200);
        ic_addr_ok = 1'b1;
        run_accepts(1);
        ic_addr_ok = 1'b0;
        ticks(3);

        // Redirect coincident with request accept
        req_q.push_back(32'h1c00_0204);
        ic_addr_ok = 1'b1;
        set_redirect(1'b1, 32'h1c00_0300);
        tick();
        chk("same_acc_taken", {64'd0, last_acc}, 65'd1);
        set_redirect(1'b0, 32'd0);
        ic_addr_ok = 1'b0;
        ticks(2);
        chk("same_acc_next_addr", {32'd0, ic_req, ic_addr}, {32'd0, 1'b1, 32'h1c00_0300});
        push_fetch(32'h1c00_0300);
        ic_addr_ok = 1'b1;
        run_accepts(1);
        ic_addr_ok = 1'b0;
        ticks(3);

        // Misaligned target raises adef and stalls until redirected
        id_ready = 1'b0;
        set_redirect(1'b1, 32'h1c00_0402);
        tick();
        set_redirect(1'b0, 32'd0);
        ic_addr_ok = 1'b1;
        tick();
        chk("adef_if_valid", {64'd0, if_valid}, 65'd1);
        chk("adef_entry", {if_pc, if_inst, if_adef}, {32'h1c00_0402, NOP, 1'b1});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("adef_no_req", {64'd0, ic_req}, 65'd0);
        end
        fetch_q.push_back({32'h1c00_0402, NOP, 1'b1});
        id_ready = 1'b1;
        set_redirect(1'b1, 32'h1c00_0500);
        tick();
        set_redirect(1'b0, 32'd0);
        push_fetch(32'h1c00_0500);
        run_accepts(1);
        ic_addr_ok = 1'b0;
        ticks(3);

        // PC wrap from the top of the address space
        set_redirect(1'b1, 32'hffff_fffc);
        tick();
        set_redirect(1'b0, 32'd0);
        push_fetch(32'hffff_fffc);
        push_fetch(32'h0000_0000);
        ic_addr_ok = 1'b1;
        run_accepts(2);
        ic_addr_ok = 1'b0;
        ticks(3);

        chk("req_queue_drained", {33'd0, 32'(req_q.size())}, 65'd0);
        chk("fetch_queue_drained", {33'd0, 32'(fetch_q.size())}, 65'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
